// File: rtl/dcache_controller.sv
// Direct-mapped, write-through, no-write-allocate data cache sequencer.
// Sits between the CPU load/store port and external memory, driving a
// 256-byte cache data memory. It holds the tags and valid bits, fills whole
// 16-byte lines (4 words) on a read miss, and writes every store through to memory.
//
// Ports:
//   clock, reset                  sole clock; synchronous active-high reset
//   in_Cpu*                       CPU request, held stable until out_CpuDone
//   out_CpuReadValue/out_CpuDone  load data and one-cycle completion pulse
//   out_CacheMemory*              cache data memory access (combinational)
//   in_CacheMemoryReadValue       cache read data, one cycle after the read
//   out_Mem*/in_Mem*              external memory request/ack handshake
//
// Optional: define DCACHE_STATS_EN to add out_HitCount/out_MissCount
// saturating 16-bit counters.
module dcache_controller #(
   parameter int unsigned AddressWidth    = 32,
   parameter int unsigned WordWidth       = 32,
   parameter int unsigned CacheAddrWidth  = 8,
   parameter int unsigned LineOffsetWidth = 4,
   parameter int unsigned IndexWidth      = 4
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      in_CpuAccessEnable,
   input  logic                      in_CpuAccessRW,
   input  logic                      in_CpuAccessBW,
   input  logic [AddressWidth-1:0]   in_CpuAddress,
   input  logic [WordWidth-1:0]      in_CpuWriteValue,
   output logic [WordWidth-1:0]      out_CpuReadValue,
   output logic                      out_CpuDone,
   output logic                      out_CacheMemoryAccessEnable,
   output logic                      out_CacheMemoryAccessRW,
   output logic                      out_CacheMemoryAccessBW,
   output logic [CacheAddrWidth-1:0] out_CacheMemoryAccessAddress,
   output logic [WordWidth-1:0]      out_CacheMemoryWriteValue,
   input  logic [WordWidth-1:0]      in_CacheMemoryReadValue,
   output logic                      out_MemRequest,
   output logic                      out_MemRW,
   output logic                      out_MemBW,
   output logic [AddressWidth-1:0]   out_MemAddress,
   output logic [WordWidth-1:0]      out_MemWriteValue,
   input  logic                      in_MemAck,
   input  logic [WordWidth-1:0]      in_MemReadValue
`ifdef DCACHE_STATS_EN
   ,
   output logic [15:0]               out_HitCount,
   output logic [15:0]               out_MissCount
`endif
);

   localparam int unsigned TagWidth = AddressWidth - CacheAddrWidth;
   localparam int unsigned NumLines = 1 << IndexWidth;
   localparam int unsigned CntWidth = LineOffsetWidth - 2;

   typedef enum logic [2:0] {
      StIdle,
      StRdWait,
      StDone,
      StFill,
      StReread,
      StWrMem
   } state_e;

   state_e                state_q, state_d;
   logic [NumLines-1:0]   valid_q, valid_d;
   logic [CntWidth-1:0]   cnt_q, cnt_d;
   logic [WordWidth-1:0]  rd_value_q, rd_value_d;
   logic [TagWidth-1:0]   tag_q [NumLines];
   logic                  tag_we;

   logic [IndexWidth-1:0] idx;
   logic [TagWidth-1:0]   addr_tag;
   logic                  hit;

   assign idx      = in_CpuAddress[CacheAddrWidth-1:LineOffsetWidth];
   assign addr_tag = in_CpuAddress[AddressWidth-1:CacheAddrWidth];
   assign hit      = valid_q[idx] && (tag_q[idx] == addr_tag);

   assign out_CpuReadValue = rd_value_q;

   always_comb begin
      state_d    = state_q;
      valid_d    = valid_q;
      cnt_d      = cnt_q;
      rd_value_d = rd_value_q;
      tag_we     = 1'b0;

      out_CpuDone                  = 1'b0;
      out_CacheMemoryAccessEnable  = 1'b0;
      out_CacheMemoryAccessRW      = 1'b0;
      out_CacheMemoryAccessBW      = 1'b0;
      out_CacheMemoryAccessAddress = '0;
      out_CacheMemoryWriteValue    = '0;
      out_MemRequest               = 1'b0;
      out_MemRW                    = 1'b0;
      out_MemBW                    = 1'b0;
      out_MemAddress               = '0;
      out_MemWriteValue            = '0;

      unique case (state_q)
         StIdle: begin
            if (in_CpuAccessEnable) begin
               if (in_CpuAccessRW) begin
                  if (hit) begin
                     out_CacheMemoryAccessEnable  = 1'b1;
                     out_CacheMemoryAccessRW      = 1'b1;
                     out_CacheMemoryAccessBW      = in_CpuAccessBW;
                     out_CacheMemoryAccessAddress = in_CpuAddress[CacheAddrWidth-1:0];
                     state_d                      = StRdWait;
                  end else begin
                     // Line is invalid until the fill finishes, so a reset
                     // mid-fill leaves no half-written line marked valid.
                     valid_d[idx] = 1'b0;
                     tag_we       = 1'b1;
                     cnt_d        = '0;
                     state_d      = StFill;
                  end
               end else begin
                  // Stores update the cache only on a hit (no write-allocate).
                  if (hit) begin
                     out_CacheMemoryAccessEnable  = 1'b1;
                     out_CacheMemoryAccessRW      = 1'b0;
                     out_CacheMemoryAccessBW      = in_CpuAccessBW;
                     out_CacheMemoryAccessAddress = in_CpuAddress[CacheAddrWidth-1:0];
                     out_CacheMemoryWriteValue    = in_CpuWriteValue;
                  end
                  state_d = StWrMem;
               end
            end
         end
         StRdWait: begin
            rd_value_d = in_CacheMemoryReadValue;
            state_d    = StDone;
         end
         StDone: begin
            out_CpuDone = 1'b1;
            state_d     = StIdle;
         end
         StFill: begin
            out_MemRequest = 1'b1;
            out_MemRW      = 1'b1;
            out_MemAddress = {tag_q[idx], idx, cnt_q, 2'b00};
            if (in_MemAck) begin
               out_CacheMemoryAccessEnable  = 1'b1;
               out_CacheMemoryAccessAddress = {idx, cnt_q, 2'b00};
               out_CacheMemoryWriteValue    = in_MemReadValue;
               cnt_d                        = cnt_q + 1'b1;
               if (cnt_q == '1) begin
                  valid_d[idx] = 1'b1;
                  state_d      = StReread;
               end
            end
         end
         StReread: begin
            out_CacheMemoryAccessEnable  = 1'b1;
            out_CacheMemoryAccessRW      = 1'b1;
            out_CacheMemoryAccessBW      = in_CpuAccessBW;
            out_CacheMemoryAccessAddress = in_CpuAddress[CacheAddrWidth-1:0];
            state_d                      = StRdWait;
         end
         StWrMem: begin
            out_MemRequest    = 1'b1;
            out_MemRW         = 1'b0;
            out_MemBW         = in_CpuAccessBW;
            out_MemAddress    = in_CpuAddress;
            out_MemWriteValue = in_CpuWriteValue;
            if (in_MemAck) begin
               state_d = StDone;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= StIdle;
         valid_q    <= '0;
         cnt_q      <= '0;
         rd_value_q <= '0;
      end else begin
         state_q    <= state_d;
         valid_q    <= valid_d;
         cnt_q      <= cnt_d;
         rd_value_q <= rd_value_d;
      end
   end

   // Tags need no reset: they are qualified by the valid bits.
   always_ff @(posedge clock) begin
      if (!reset && tag_we) begin
         tag_q[idx] <= addr_tag;
      end
   end

`ifdef DCACHE_STATS_EN
   logic [15:0] hit_cnt_q, hit_cnt_d;
   logic [15:0] miss_cnt_q, miss_cnt_d;
   logic        accept;

   assign accept = (state_q == StIdle) && in_CpuAccessEnable;

   always_comb begin
      hit_cnt_d  = hit_cnt_q;
      miss_cnt_d = miss_cnt_q;
      if (accept && hit && (hit_cnt_q != 16'hFFFF)) begin
         hit_cnt_d = hit_cnt_q + 16'd1;
      end
      if (accept && in_CpuAccessRW && !hit && (miss_cnt_q != 16'hFFFF)) begin
         miss_cnt_d = miss_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         hit_cnt_q  <= hit_cnt_d;
         miss_cnt_q <= miss_cnt_d;
      end
   end

   assign out_HitCount  = hit_cnt_q;
   assign out_MissCount = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_controller.sv
module tb_dcache_controller;

   logic        clock;
   logic        reset;
   logic        in_CpuAccessEnable;
   logic        in_CpuAccessRW;
   logic        in_CpuAccessBW;
   logic [31:0] in_CpuAddress;
   logic [31:0] in_CpuWriteValue;
   logic [31:0] out_CpuReadValue;
   logic        out_CpuDone;
   logic        out_CacheMemoryAccessEnable;
   logic        out_CacheMemoryAccessRW;
   logic        out_CacheMemoryAccessBW;
   logic [7:0]  out_CacheMemoryAccessAddress;
   logic [31:0] out_CacheMemoryWriteValue;
   logic [31:0] in_CacheMemoryReadValue = 32'h0;
   logic        out_MemRequest;
   logic        out_MemRW;
   logic        out_MemBW;
   logic [31:0] out_MemAddress;
   logic [31:0] out_MemWriteValue;
   logic        in_MemAck = 1'b0;
   logic [31:0] in_MemReadValue = 32'h0;

   dcache_controller dut (
      .clock                        (clock),
      .reset                        (reset),
      .in_CpuAccessEnable           (in_CpuAccessEnable),
      .in_CpuAccessRW               (in_CpuAccessRW),
      .in_CpuAccessBW               (in_CpuAccessBW),
      .in_CpuAddress                (in_CpuAddress),
      .in_CpuWriteValue             (in_CpuWriteValue),
      .out_CpuReadValue             (out_CpuReadValue),
      .out_CpuDone                  (out_CpuDone),
      .out_CacheMemoryAccessEnable  (out_CacheMemoryAccessEnable),
      .out_CacheMemoryAccessRW      (out_CacheMemoryAccessRW),
      .out_CacheMemoryAccessBW      (out_CacheMemoryAccessBW),
      .out_CacheMemoryAccessAddress (out_CacheMemoryAccessAddress),
      .out_CacheMemoryWriteValue    (out_CacheMemoryWriteValue),
      .in_CacheMemoryReadValue      (in_CacheMemoryReadValue),
      .out_MemRequest               (out_MemRequest),
      .out_MemRW                    (out_MemRW),
      .out_MemBW                    (out_MemBW),
      .out_MemAddress               (out_MemAddress),
      .out_MemWriteValue            (out_MemWriteValue),
      .in_MemAck                    (in_MemAck),
      .in_MemReadValue              (in_MemReadValue)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h want=%h", name, got, exp);
      end
   endtask

   // ---------------- external memory model ----------------
   logic [31:0] ext_mem [logic [31:0]];
   logic        ack_block = 1'b0;
   int          wait_cnt  = 0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      logic [31:0] al;
      al = {a[31:2], 2'b00};
      if (ext_mem.exists(al)) return ext_mem[al];
      return {16'hDEAD, al[15:0]};
   endfunction

   // Ack every second cycle of a held request.
   always @(negedge clock) begin
      if (out_MemRequest && !ack_block && !reset) begin
         if (wait_cnt >= 1) begin
            in_MemAck       = 1'b1;
            in_MemReadValue = mem_word(out_MemAddress);
            wait_cnt        = 0;
         end else begin
            in_MemAck = 1'b0;
            wait_cnt++;
         end
      end else begin
         in_MemAck = 1'b0;
         wait_cnt  = 0;
      end
   end

   // Transaction logs, cleared at the start of each access.
   logic [31:0] fill_addr_q [$];
   int          memwr_cnt = 0;
   int          cwr_cnt   = 0;
   int          cacc_cnt  = 0;
   logic [31:0] last_mw_addr = 32'h0;
   logic        last_mw_bw   = 1'b0;

   logic [7:0]  cmem [256];

   always @(posedge clock) begin
      logic [31:0] w;
      logic [7:0]  a;
      if (!reset && out_MemRequest && in_MemAck) begin
         if (out_MemRW) begin
            fill_addr_q.push_back(out_MemAddress);
         end else begin
            memwr_cnt++;
            last_mw_addr = out_MemAddress;
            last_mw_bw   = out_MemBW;
            w = mem_word(out_MemAddress);
            if (out_MemBW) w[8*out_MemAddress[1:0] +: 8] = out_MemWriteValue[7:0];
            else           w = out_MemWriteValue;
            ext_mem[{out_MemAddress[31:2], 2'b00}] = w;
         end
      end
      if (out_CacheMemoryAccessEnable) begin
         cacc_cnt++;
         a = out_CacheMemoryAccessAddress;
         if (!out_CacheMemoryAccessRW) begin
            cwr_cnt++;
            if (out_CacheMemoryAccessBW) begin
               cmem[a] = out_CacheMemoryWriteValue[7:0];
            end else begin
               for (int k = 0; k < 4; k++)
                  cmem[{a[7:2], 2'b00} + 8'(k)] = out_CacheMemoryWriteValue[8*k +: 8];
            end
         end else begin
            if (out_CacheMemoryAccessBW) begin
               in_CacheMemoryReadValue <= {4{cmem[a]}};
            end else begin
               a = {a[7:2], 2'b00};
               in_CacheMemoryReadValue <= {cmem[a+8'd3], cmem[a+8'd2], cmem[a+8'd1], cmem[a]};
            end
         end
      end
   end

   // ---------------- vectors ----------------
   typedef struct {
      logic        rw;
      logic        bw;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      int          exp_fills;
      logic [31:0] exp_fill_base;
      int          exp_memwr;
      int          exp_cwr;
      int          exp_cacc;
      int          exp_lat;   // -1 = not checked
   } vec_t;

   function automatic vec_t mk(input logic rw, input logic bw, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] exp_rdata,
                               input int fills, input logic [31:0] base, input int memwr,
                               input int cwr, input int cacc, input int lat);
      vec_t v;
      v.rw = rw; v.bw = bw; v.addr = addr; v.wdata = wdata; v.exp_rdata = exp_rdata;
      v.exp_fills = fills; v.exp_fill_base = base; v.exp_memwr = memwr;
      v.exp_cwr = cwr; v.exp_cacc = cacc; v.exp_lat = lat;
      return v;
   endfunction

   task automatic run_vec(input string tag, input vec_t v);
      logic [31:0] rdata;
      int          lat;
      bit          done;
      @(negedge clock);
      fill_addr_q.delete();
      memwr_cnt = 0; cwr_cnt = 0; cacc_cnt = 0;
      in_CpuAccessRW     = v.rw;
      in_CpuAccessBW     = v.bw;
      in_CpuAddress      = v.addr;
      in_CpuWriteValue   = v.wdata;
      in_CpuAccessEnable = 1'b1;
      done = 1'b0; lat = 0; rdata = 32'h0;
      for (int k = 0; k < 200; k++) begin
         @(posedge clock);
         #1;
         lat++;
         if (out_CpuDone) begin
            done  = 1'b1;
            rdata = out_CpuReadValue;
            break;
         end
      end
      @(negedge clock);
      in_CpuAccessEnable = 1'b0;
      check($sformatf("%s done", tag), {31'b0, done}, 32'd1);
      if (v.rw) check($sformatf("%s rdata", tag), rdata, v.exp_rdata);
      check($sformatf("%s fills", tag), fill_addr_q.size(), v.exp_fills);
      for (int j = 0; j < v.exp_fills && j < fill_addr_q.size(); j++)
         check($sformatf("%s fill_addr%0d", tag, j), fill_addr_q[j], v.exp_fill_base + 32'(4 * j));
      check($sformatf("%s memwr", tag), memwr_cnt, v.exp_memwr);
      if (v.exp_memwr > 0) begin
         check($sformatf("%s mw_addr", tag), last_mw_addr, v.addr);
         check($sformatf("%s mw_bw", tag), {31'b0, last_mw_bw}, {31'b0, v.bw});
      end
      check($sformatf("%s cache_wr", tag), cwr_cnt, v.exp_cwr);
      check($sformatf("%s cache_acc", tag), cacc_cnt, v.exp_cacc);
      if (v.exp_lat >= 0) check($sformatf("%s latency", tag), lat, v.exp_lat);
   endtask

   vec_t vecs [10];

   initial begin
      #500000;
      $display("FAIL watchdog: got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      //        rw    bw    addr          wdata         rdata         fl base          mw cw ca lat
      vecs[0] = mk(1'b1, 1'b0, 32'h00001230, 32'h0,        32'h11111111, 4, 32'h00001230, 0, 4, 5, -1);
      vecs[1] = mk(1'b1, 1'b0, 32'h00001234, 32'h0,        32'h22222222, 0, 32'h0,        0, 0, 1, 2);
      vecs[2] = mk(1'b0, 1'b1, 32'h00001235, 32'h000000AB, 32'h0,        0, 32'h0,        1, 1, 1, -1);
      vecs[3] = mk(1'b1, 1'b0, 32'h00001234, 32'h0,        32'h2222AB22, 0, 32'h0,        0, 0, 1, 2);
      vecs[4] = mk(1'b1, 1'b1, 32'h00001235, 32'h0,        32'hABABABAB, 0, 32'h0,        0, 0, 1, 2);
      vecs[5] = mk(1'b0, 1'b0, 32'h00005678, 32'hCAFEF00D, 32'h0,        0, 32'h0,        1, 0, 0, -1);
      vecs[6] = mk(1'b1, 1'b0, 32'h00005678, 32'h0,        32'hCAFEF00D, 4, 32'h00005670, 0, 4, 5, -1);
      vecs[7] = mk(1'b1, 1'b0, 32'h00009230, 32'h0,        32'hDEAD9230, 4, 32'h00009230, 0, 4, 5, -1);
      vecs[8] = mk(1'b1, 1'b0, 32'h00001230, 32'h0,        32'h11111111, 4, 32'h00001230, 0, 4, 5, -1);
      vecs[9] = mk(1'b1, 1'b0, 32'h0000123C, 32'h0,        32'h44444444, 0, 32'h0,        0, 0, 1, 2);

      ext_mem[32'h00001230] = 32'h11111111;
      ext_mem[32'h00001234] = 32'h22222222;
      ext_mem[32'h00001238] = 32'h33333333;
      ext_mem[32'h0000123C] = 32'h44444444;
      for (int i = 0; i < 256; i++) cmem[i] = 8'h00;

      reset = 1'b1;
      in_CpuAccessEnable = 1'b0;
      in_CpuAccessRW     = 1'b0;
      in_CpuAccessBW     = 1'b0;
      in_CpuAddress      = 32'h0;
      in_CpuWriteValue   = 32'h0;
      repeat (3) @(posedge clock);
      #1;
      check("rst done", {31'b0, out_CpuDone}, 32'd0);
      check("rst rdata", out_CpuReadValue, 32'h0);
      check("rst memreq", {31'b0, out_MemRequest}, 32'd0);
      check("rst cache_en", {31'b0, out_CacheMemoryAccessEnable}, 32'd0);
      @(negedge clock);
      reset = 1'b0;

      for (int i = 0; i < 10; i++) run_vec($sformatf("v%0d", i), vecs[i]);

      // Reset while the fill waits for its second word.
      @(negedge clock);
      fill_addr_q.delete();
      in_CpuAccessRW     = 1'b1;
      in_CpuAccessBW     = 1'b0;
      in_CpuAddress      = 32'h00002340;
      in_CpuAccessEnable = 1'b1;
      for (int k = 0; k < 100; k++) begin
         @(negedge clock);
         if (fill_addr_q.size() >= 1) break;
      end
      ack_block = 1'b1;
      check("midfill first_ack", fill_addr_q.size(), 1);
      @(negedge clock);
      check("midfill req_held", {31'b0, out_MemRequest}, 32'd1);
      check("midfill addr2", out_MemAddress, 32'h00002344);
      reset = 1'b1;
      in_CpuAccessEnable = 1'b0;
      @(posedge clock);
      #1;
      check("midfill req_drop", {31'b0, out_MemRequest}, 32'd0);
      check("midfill done", {31'b0, out_CpuDone}, 32'd0);
      check("midfill rdata_clr", out_CpuReadValue, 32'h0);
      @(negedge clock);
      reset = 1'b0;
      ack_block = 1'b0;

      run_vec("r0", mk(1'b1, 1'b0, 32'h00002340, 32'h0, 32'hDEAD2340, 4, 32'h00002340, 0, 4, 5, -1));
      run_vec("r1", mk(1'b1, 1'b0, 32'h00002348, 32'h0, 32'hDEAD2348, 0, 32'h0, 0, 0, 1, 2));
      run_vec("r2", mk(1'b1, 1'b0, 32'h00001234, 32'h0, 32'h2222AB22, 4, 32'h00001230, 0, 4, 5, -1));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
